decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RISC-V instruction decode stage with a valid/ready handshake on both sides.
- Classifies each instruction by opcode, extracts register indices and the type-specific immediate sign-extended to XLEN, and produces operand-usage flags.
- Decoded results are buffered in a DEPTH-entry FIFO so fetch and issue are decoupled.
- Sits between the fetch queue and the register-read/issue stage.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets immediate and PC width.
DEPTH, 4, output FIFO entries; power of two, >= 2.
INSTRUCTION_LENGTH, 32, instruction word width; fixed at 32.

Ports:
clk  input  1  clock, all state on rising edge.
reset_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous; empties the FIFO.
in_valid  input  1  instruction and PC valid.
in_ready  output  1  stage can accept this cycle.
in_instr  input  32  instruction word.
in_pc  input  XLEN  PC of in_instr.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer takes the head entry.
out_pc  output  XLEN  PC of head.
out_type  output  3  R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
out_rd / out_rs1 / out_rs2  output  5 each  register indices.
out_imm  output  XLEN  decoded immediate.
out_use  output  3  {uses_rd, uses_rs1, uses_rs2}.

Behaviour:
- Reset (reset_n low, asynchronous): FIFO empty, pointers and count 0. out_valid=0, in_ready=1, and every data output 0.
- Accept: in_valid && in_ready pushes the decoded entry. in_ready = !full, driven from registered count only, with no combinational path from out_ready.
- Pop: out_valid && out_ready. out_valid = count!=0. Outputs always show the FIFO head.
- Latency: an entry pushed in cycle N is visible on the outputs at N+1. There is no bypass when the FIFO is empty.
- Simultaneous push and pop leave the count unchanged. This is legal at any count below DEPTH. At full, in_ready=0, so no push occurs.
- Pointers wrap modulo DEPTH.
- flush has priority over push and pop in the same cycle. The next cycle shows count=0, out_valid=0 and in_ready=1.
- Reset asserted mid-operation discards all entries immediately.
- Holding rule: while out_valid && !out_ready, all out_* signals stay stable.
- Type decode from in_instr[6:0]:
  - R: 0110011, 0111011.
  - I: 0010011, 0011011, 0000011, 1100111, 1110011, 0001111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Anything else: NONE.
- Register fields: rd=[11:7], rs1=[19:15], rs2=[24:20], always extracted raw.
- out_use per type:
  - R: 111.
  - I: 110.
  - S and B: 011.
  - U and J: 100.
  - NONE: 000.
  - uses_rd is forced to 0 whenever rd==0.
- Immediates (s = instr[31], sign-extended to XLEN):
  - I: sext([31:20]).
  - I-shift (opcode 0010011/0011011 with funct3 001 or 101): zero-extended shamt. Use [25:20] when XLEN=64 and opcode 0010011, otherwise [24:20].
  - S: sext({[31:25],[11:7]}).
  - B: sext({[31],[7],[30:25],[11:8],0}).
  - U: sext({[31:12],12'b0}).
  - J: sext({[31],[19:12],[20],[30:21],0}).
  - R and NONE: 0.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- When defined:
  - Adds output out_illegal (1 bit), stored per entry.
  - It is set when the type is NONE, when in_instr[1:0]!=2'b11, or when opcode 0111011/0011011 appears with XLEN=32.
  - Such entries report out_type=NONE, out_use=000 and out_imm=in_instr zero-extended, for the trap handler.
- When undefined:
  - The port is absent.
  - Those entries are still queued with out_type=NONE, out_use=000 and out_imm=0.

Test Plan:
- Reset, then push addi x5,x6,-1 (0xFFF30293) with out_ready=1 -> one cycle later out_type=1, rd=5, rs1=6, out_imm=0xFFFFFFFF, out_use=110.
- Push beq x1,x2,-4 (0xFE208EE3) -> type=3, out_imm=0xFFFFFFFC, out_use=011; this checks that B-immediate bit 11 comes from instr[7].
- Push jal x1,+2048 (0x001000EF) -> type=5, out_imm=0x00000800. Then lui x3,0x80000 (0x800001B7) with XLEN=64 -> out_imm=0xFFFFFFFF80000000.
- Hold out_ready=0 and push 5 instructions with DEPTH=4 -> in_ready drops after the 4th push and the 5th waits. Head outputs stay stable. Releasing out_ready drains in order, with simultaneous push/pop keeping the count.
- Fill 3 entries, then assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the concurrent instruction is dropped.
- Push 0x00000000 -> type=7, out_use=000. With DECODE_ILLEGAL_EN: out_illegal=1, out_imm=0. Also push slli x1,x1,5 (0x00509093) -> out_imm=5.

Source files
------------

// File: rtl/decode_stage.sv
// RISC-V decode stage: opcode classify, immediate extract, DEPTH-entry output FIFO.
// Optional `DECODE_ILLEGAL_EN adds out_illegal and traps raw instr into out_imm.
module decode_stage #(
    parameter int XLEN               = 32,
    parameter int DEPTH              = 4,
    parameter int INSTRUCTION_LENGTH = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTRUCTION_LENGTH-1:0] in_instr,
    input  logic [XLEN-1:0]               in_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_pc,
    output logic [2:0]                    out_type,
    output logic [4:0]                    out_rd,
    output logic [4:0]                    out_rs1,
    output logic [4:0]                    out_rs2,
    output logic [XLEN-1:0]               out_imm,
    output logic [2:0]                    out_use
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic                          out_illegal
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [2:0] T_R    = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_NONE = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      typ;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [2:0]      use_f;
`ifdef DECODE_ILLEGAL_EN
        logic            ill;
`endif
    } entry_t;

    entry_t          dec;
    entry_t          head;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;

    logic [6:0]        op;
    logic [2:0]        f3;
    logic              w_op;
    logic              illegal;
    logic [5:0]        shamt;
    logic signed [31:0] imm32;
    logic              push;
    logic              pop;

    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];

    always_comb begin
        dec       = '0;
        dec.pc    = in_pc;
        dec.rd    = in_instr[11:7];
        dec.rs1   = in_instr[19:15];
        dec.rs2   = in_instr[24:20];
        dec.typ   = T_NONE;
        imm32     = '0;
        shamt     = '0;
        unique case (op)
            7'b0110011, 7'b0111011: dec.typ = T_R;
            7'b0010011, 7'b0011011, 7'b0000011,
            7'b1100111, 7'b1110011, 7'b0001111: dec.typ = T_I;
            7'b0100011: dec.typ = T_S;
            7'b1100011: dec.typ = T_B;
            7'b0110111, 7'b0010111: dec.typ = T_U;
            7'b1101111: dec.typ = T_J;
            default: dec.typ = T_NONE;
        endcase
        w_op = (op == 7'b0111011) || (op == 7'b0011011);
        illegal = (dec.typ == T_NONE) || (in_instr[1:0] != 2'b11)
                  || (w_op && XLEN == 32);

        // RV64 slli/srli/srai carry a 6-bit shamt; the W forms keep 5 bits
        if (XLEN == 64 && op == 7'b0010011)
            shamt = in_instr[25:20];
        else
            shamt = {1'b0, in_instr[24:20]};

        unique case (dec.typ)
            T_R: dec.use_f = 3'b111;
            T_I: dec.use_f = 3'b110;
            T_S, T_B: dec.use_f = 3'b011;
            T_U, T_J: dec.use_f = 3'b100;
            default: dec.use_f = 3'b000;
        endcase
        if (dec.rd == 5'd0)
            dec.use_f[2] = 1'b0;

        unique case (dec.typ)
            T_I: begin
                if ((op == 7'b0010011 || op == 7'b0011011)
                    && (f3 == 3'b001 || f3 == 3'b101))
                    imm32 = 32'(shamt);
                else
                    imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            T_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                          in_instr[11:7]};
            T_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
            T_U: imm32 = {in_instr[31:12], 12'b0};
            T_J: imm32 = {{11{in_instr[31]}}, in_instr[31],
                          in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        dec.imm = XLEN'(imm32);

        if (illegal) begin
            dec.typ   = T_NONE;
            dec.use_f = 3'b000;
`ifdef DECODE_ILLEGAL_EN
            dec.imm   = XLEN'(in_instr);
            dec.ill   = 1'b1;
`else
            dec.imm   = '0;
`endif
        end
    end

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)
                count_d = count_q + (AW+1)'(1);
            else if (pop && !push)
                count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign out_pc   = head.pc;
    assign out_type = head.typ;
    assign out_rd   = head.rd;
    assign out_rs1  = head.rs1;
    assign out_rs2  = head.rs2;
    assign out_imm  = head.imm;
    assign out_use  = head.use_f;
`ifdef DECODE_ILLEGAL_EN
    assign out_illegal = head.ill;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage, with directed decode cases.
// Build with +define+DECODE_ILLEGAL_EN to also cover out_illegal.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk;
    logic            reset_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [2:0]      out_type;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_use;
`ifdef DECODE_ILLEGAL_EN
    logic            out_illegal;
`endif

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .INSTRUCTION_LENGTH(32)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .in_pc(in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_type(out_type),
        .out_rd(out_rd),
        .out_rs1(out_rs1),
        .out_rs2(out_rs2),
        .out_imm(out_imm),
        .out_use(out_use)
`ifdef DECODE_ILLEGAL_EN
        ,
        .out_illegal(out_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        int              t;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [2:0]      u;
        logic            ill;
    } exp_t;

    exp_t            q[$];
    int              n_checks;
    int              n_errors;
    logic [XLEN-1:0] pc_ctr;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] i,
                                   input logic [XLEN-1:0] pc);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        longint     v;
        op    = i[6:0];
        f3    = i[14:12];
        e.pc  = pc;
        e.rd  = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        if (op inside {7'h33, 7'h3B}) e.t = 0;
        else if (op inside {7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h0F}) e.t = 1;
        else if (op == 7'h23) e.t = 2;
        else if (op == 7'h63) e.t = 3;
        else if (op inside {7'h37, 7'h17}) e.t = 4;
        else if (op == 7'h6F) e.t = 5;
        else e.t = 7;
        e.ill = (e.t == 7) || (i[1:0] != 2'b11)
                || (XLEN == 32 && op inside {7'h3B, 7'h1B});
        v = 0;
        case (e.t)
            1: begin
                if (op inside {7'h13, 7'h1B} && f3 inside {3'd1, 3'd5}) begin
                    if (XLEN == 64 && op == 7'h13) v = longint'(i[25:20]);
                    else v = longint'(i[24:20]);
                end else begin
                    v = longint'(i[31:20]);
                    if (i[31]) v -= 4096;
                end
            end
            2: begin
                v = longint'({i[31:25], i[11:7]});
                if (i[31]) v -= 4096;
            end
            3: begin
                v = longint'({i[31], i[7], i[30:25], i[11:8], 1'b0});
                if (i[31]) v -= 8192;
            end
            4: begin
                v = longint'(i[31:12]) * 4096;
                if (i[31]) v -= 64'h1_0000_0000;
            end
            5: begin
                v = longint'({i[31], i[19:12], i[20], i[30:21], 1'b0});
                if (i[31]) v -= 64'h20_0000;
            end
            default: v = 0;
        endcase
        e.imm = v[XLEN-1:0];
        case (e.t)
            0: e.u = 3'b111;
            1: e.u = 3'b110;
            2, 3: e.u = 3'b011;
            4, 5: e.u = 3'b100;
            default: e.u = 3'b000;
        endcase
        if (e.rd == 5'd0) e.u[2] = 1'b0;
        if (e.ill) begin
            e.t = 7;
            e.u = 3'b000;
`ifdef DECODE_ILLEGAL_EN
            e.imm = XLEN'(i);
`else
            e.imm = '0;
`endif
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [14];
        logic [31:0] r;
        ops = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73,
                7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13};
        r = $urandom;
        if ($urandom_range(0, 7) != 0)
            r[6:0] = ops[$urandom_range(0, 13)];
        return r;
    endfunction

    // Called at a falling edge: compare head, drive one cycle, advance model.
    task automatic cyc(input logic v, input logic [31:0] ins,
                       input logic rdy, input logic fl);
        exp_t e;
        logic acc;
        logic pop;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < DEPTH);
        if (q.size() != 0) begin
            e = q[0];
            chk("out_pc", out_pc, e.pc);
            chk("out_type", out_type, e.t[2:0]);
            chk("out_rd", out_rd, e.rd);
            chk("out_rs1", out_rs1, e.rs1);
            chk("out_rs2", out_rs2, e.rs2);
            chk("out_imm", out_imm, e.imm);
            chk("out_use", out_use, e.u);
`ifdef DECODE_ILLEGAL_EN
            chk("out_illegal", out_illegal, e.ill);
`endif
        end
        acc       = v && (q.size() < DEPTH);
        pop       = (q.size() != 0) && rdy;
        pc_ctr    = pc_ctr + XLEN'(4);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc_ctr;
        out_ready = rdy;
        flush     = fl;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(model(ins, pc_ctr));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && q.size() != 0; k++)
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic directed(input string tag, input logic [31:0] ins,
                            input logic [2:0] t, input logic [XLEN-1:0] imm,
                            input logic [2:0] u);
        drain();
        cyc(1'b1, ins, 1'b1, 1'b0);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_type"}, out_type, t);
        chk({tag, "_imm"}, out_imm, imm);
        chk({tag, "_use"}, out_use, u);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        pc_ctr    = XLEN'(32'h1000);
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_pc", out_pc, '0);
        chk("rst_out_imm", out_imm, '0);
        chk("rst_out_type", out_type, 3'd0);
        chk("rst_out_use", out_use, 3'd0);

        directed("addi", 32'hFFF30293, 3'd1, XLEN'(32'hFFFFFFFF), 3'b110);
        chk("addi_rd", 64'(model(32'hFFF30293, '0).rd), 64'd5);
        directed("beq", 32'hFE208EE3, 3'd3, XLEN'(32'hFFFFFFFC), 3'b011);
        directed("jal", 32'h001000EF, 3'd5, XLEN'(32'h00000800), 3'b100);
        directed("lui", 32'h800001B7, 3'd4, XLEN'(32'h80000000), 3'b100);
        directed("zero", 32'h00000000, 3'd7, '0, 3'b000);
        directed("slli", 32'h00509093, 3'd1, XLEN'(5), 3'b110);
        directed("addiw32", 32'h0010809B, 3'd7,
`ifdef DECODE_ILLEGAL_EN
                 XLEN'(32'h0010809B),
`else
                 '0,
`endif
                 3'b000);

        // fill to full with consumer stalled, then drain while pushing
        drain();
        for (int k = 0; k < 5; k++)
            cyc(1'b1, rand_instr(), 1'b0, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_out_valid", out_valid, 1'b1);
        for (int k = 0; k < 6; k++)
            cyc(1'b1, rand_instr(), 1'b1, 1'b0);
        drain();

        // flush wins over a concurrent push
        for (int k = 0; k < 3; k++)
            cyc(1'b1, rand_instr(), 1'b0, 1'b0);
        cyc(1'b1, rand_instr(), 1'b1, 1'b1);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // asynchronous reset mid-stream
        for (int k = 0; k < 2; k++)
            cyc(1'b1, rand_instr(), 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_in_ready", in_ready, 1'b1);
        chk("mrst_out_imm", out_imm, '0);
        q.delete();
        #1 reset_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(0, 9) < 7, rand_instr(),
                $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
        drain();
        chk("end_out_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
